// File: rtl/systolic_weight_sequencer.sv
// Weight-load sequencer for the PE array: takes a load command, accepts one
// weight row per handshake beat and drives row ID plus per-column load
// enables through PIPE_DEPTH register stages, optionally skewed diagonally.
module systolic_weight_sequencer #(
    parameter int PE_COL     = 8,
    parameter int PE_ROW     = 8,
    parameter int BIT_ROW_ID = 3,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  i_Start,
    input  logic [BIT_ROW_ID:0]   i_Num_Rows,
    input  logic [PE_COL-1:0]     i_Col_Mask,
    input  logic                  i_Mode,
    input  logic                  i_Abort,
    input  logic                  i_W_Valid,
    output logic                  o_W_Ready,
    output logic [BIT_ROW_ID-1:0] o_Systolic_En_ID,
    output logic [PE_COL-1:0]     o_Systolic_En_W,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int CW = BIT_ROW_ID + 1;
    localparam int DW = $clog2(PIPE_DEPTH + PE_COL) + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  num_q, row_cnt, num_in;
    logic [PE_COL-1:0]              mask_q;
    logic                           mode_q;
    logic [DW-1:0]                  drn_cnt, drn_len;
    logic                           beat, last_row, drn_end, cmd_take;

    // vld_pipe carries "a beat was injected" toward the array; id_pipe its row ID
    logic [PIPE_DEPTH:1]                 vld_pipe;
    logic [PIPE_DEPTH:1][BIT_ROW_ID-1:0] id_pipe;
    // shared diagonal delay line of the column-0 valid; column c taps stage c
    logic [PE_COL-1:1]                   skew_sr;
    logic                                vld_out;

    assign num_in   = (i_Num_Rows > CW'(PE_ROW)) ? CW'(PE_ROW) : i_Num_Rows;
    assign cmd_take = (state == S_IDLE) && i_Start && !i_Abort;
    assign last_row = ((row_cnt + CW'(1)) == num_q);
    assign drn_len  = mode_q ? DW'(PIPE_DEPTH + PE_COL - 1) : DW'(PIPE_DEPTH);
    assign drn_end  = (drn_cnt == (drn_len - DW'(1)));

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state, handshake and beat qualification; abort overrides everything
    always_comb begin
        state_nxt = state;
        o_W_Ready = 1'b0;
        beat      = 1'b0;
        if (i_Abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_Start) state_nxt = (i_Num_Rows == '0) ? S_DONE : S_LOAD;
                S_LOAD: begin
                    o_W_Ready = 1'b1;
                    beat      = i_W_Valid;
                    if (beat && last_row) state_nxt = S_DRAIN;
                end
                S_DRAIN: if (drn_end) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // command latch, row counter and drain counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_q   <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            row_cnt <= '0;
            drn_cnt <= '0;
        end else begin
            if (cmd_take) begin
                num_q   <= num_in;
                mask_q  <= i_Col_Mask;
                mode_q  <= i_Mode;
                row_cnt <= '0;
            end else if (beat) begin
                row_cnt <= row_cnt + CW'(1);
            end
            drn_cnt <= (state == S_DRAIN && !i_Abort) ? drn_cnt + DW'(1) : '0;
        end
    end

    // output pipeline and skew line; abort flushes anything in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            skew_sr  <= '0;
        end else if (i_Abort) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            skew_sr  <= '0;
        end else begin
            vld_pipe[1] <= beat;
            id_pipe[1]  <= beat ? row_cnt[BIT_ROW_ID-1:0] : '0;
            for (int i = 2; i <= PIPE_DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
            // broadcast loads keep the skew line quiet
            skew_sr[1] <= vld_pipe[PIPE_DEPTH] & mode_q;
            for (int i = 2; i < PE_COL; i++) skew_sr[i] <= skew_sr[i-1];
        end
    end

    assign vld_out = vld_pipe[PIPE_DEPTH];

    // per-column enable: broadcast taps the pipe end, skew taps stage c
    for (genvar c = 0; c < PE_COL; c++) begin : g_col
        if (c == 0) begin : g_c0
            assign o_Systolic_En_W[c] = mask_q[c] & vld_out;
        end else begin : g_cn
            assign o_Systolic_En_W[c] = mask_q[c] & (mode_q ? skew_sr[c] : vld_out);
        end
    end

    assign o_Systolic_En_ID = id_pipe[PIPE_DEPTH];
    assign o_Busy           = (state != S_IDLE);
    assign o_Done           = (state == S_DONE);

endmodule

// File: tb/tb_systolic_weight_sequencer.sv
// Bench: two sequencers (pipe depth 1 and 4) share one stimulus stream.
// A schedule model books each accepted beat's enables at absolute future
// cycles; a negedge process compares every output every cycle.
module tb_systolic_weight_sequencer;
    localparam int NC = 8, NR = 8, BR = 3, CYC = 4096;

    logic CLK = 1'b0, RST_N = 1'b0;
    logic i_Start = 1'b0, i_Mode = 1'b0, i_Abort = 1'b0, i_W_Valid = 1'b0;
    logic [BR:0]   i_Num_Rows = '0;
    logic [NC-1:0] i_Col_Mask = '0;

    logic [1:0][NC-1:0] a_en;
    logic [1:0][BR-1:0] a_id;
    logic [1:0]         a_rdy, a_busy, a_done;

    int checks = 0, errors = 0, cyc = 0;

    // model: phase 0 idle, 1 load, 2 drain, 3 done
    int            ph[2], left[2], rid[2], drn[2];
    logic [NC-1:0] msk[2];
    logic          md[2];
    logic [NC-1:0] sch_en[2][CYC];
    logic [BR-1:0] sch_id[2][CYC];
    logic [NC-1:0] log_en[2][CYC];
    logic [BR-1:0] log_id[2][CYC];
    logic          log_done[2][CYC], log_busy[2][CYC];

    systolic_weight_sequencer #(.PE_COL(NC), .PE_ROW(NR), .BIT_ROW_ID(BR), .PIPE_DEPTH(1)) u_d1 (
        .CLK(CLK), .RST_N(RST_N), .i_Start(i_Start), .i_Num_Rows(i_Num_Rows),
        .i_Col_Mask(i_Col_Mask), .i_Mode(i_Mode), .i_Abort(i_Abort), .i_W_Valid(i_W_Valid),
        .o_W_Ready(a_rdy[0]), .o_Systolic_En_ID(a_id[0]), .o_Systolic_En_W(a_en[0]),
        .o_Busy(a_busy[0]), .o_Done(a_done[0]));

    systolic_weight_sequencer #(.PE_COL(NC), .PE_ROW(NR), .BIT_ROW_ID(BR), .PIPE_DEPTH(4)) u_d4 (
        .CLK(CLK), .RST_N(RST_N), .i_Start(i_Start), .i_Num_Rows(i_Num_Rows),
        .i_Col_Mask(i_Col_Mask), .i_Mode(i_Mode), .i_Abort(i_Abort), .i_W_Valid(i_W_Valid),
        .o_W_Ready(a_rdy[1]), .o_Systolic_En_ID(a_id[1]), .o_Systolic_En_W(a_en[1]),
        .o_Busy(a_busy[1]), .o_Done(a_done[1]));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // every cycle: compare against the model, then advance it with this cycle's inputs
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 1 : 4;
            log_en[k][cyc]   = a_en[k];
            log_id[k][cyc]   = a_id[k];
            log_done[k][cyc] = a_done[k];
            log_busy[k][cyc] = a_busy[k];
            if (!RST_N) begin
                chk($sformatf("reset_out%0d", k),
                    int'({a_en[k], a_id[k], a_rdy[k], a_busy[k], a_done[k]}), 0);
                ph[k] = 0;
                for (int t = cyc; t < CYC; t++) begin
                    sch_en[k][t] = '0;
                    sch_id[k][t] = '0;
                end
            end else begin
                chk($sformatf("en%0d", k),   int'(a_en[k]),   int'(sch_en[k][cyc]));
                chk($sformatf("id%0d", k),   int'(a_id[k]),   int'(sch_id[k][cyc]));
                chk($sformatf("rdy%0d", k),  int'(a_rdy[k]),  int'(ph[k] == 1 && !i_Abort));
                chk($sformatf("busy%0d", k), int'(a_busy[k]), int'(ph[k] != 0));
                chk($sformatf("done%0d", k), int'(a_done[k]), int'(ph[k] == 3));
                if (i_Abort) begin
                    if (ph[k] != 0)
                        for (int t = cyc + 1; t < CYC; t++) begin
                            sch_en[k][t] = '0;
                            sch_id[k][t] = '0;
                        end
                    ph[k] = 0;
                end else begin
                    case (ph[k])
                        0: if (i_Start) begin
                            left[k] = (int'(i_Num_Rows) > NR) ? NR : int'(i_Num_Rows);
                            msk[k]  = i_Col_Mask;
                            md[k]   = i_Mode;
                            rid[k]  = 0;
                            ph[k]   = (left[k] == 0) ? 3 : 1;
                        end
                        1: if (i_W_Valid) begin
                            for (int c = 0; c < NC; c++)
                                if (msk[k][c]) begin
                                    int t;
                                    t = cyc + d + (md[k] ? c : 0);
                                    if (t < CYC) sch_en[k][t][c] = 1'b1;
                                end
                            if (cyc + d < CYC) sch_id[k][cyc+d] = BR'(rid[k]);
                            rid[k]++;
                            left[k]--;
                            if (left[k] == 0) begin
                                ph[k]  = 2;
                                drn[k] = d + (md[k] ? NC - 1 : 0);
                            end
                        end
                        2: begin
                            drn[k]--;
                            if (drn[k] == 0) ph[k] = 3;
                        end
                        default: ph[k] = 0;
                    endcase
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmd(input int n, input logic [NC-1:0] m, input logic mode);
        i_Start = 1'b1; i_Num_Rows = 4'(n); i_Col_Mask = m; i_Mode = mode;
    endtask

    task automatic quiet();
        i_Start = 1'b0; i_Abort = 1'b0; i_W_Valid = 1'b0;
    endtask

    int s, any;
    int sk_tab[10] = '{'h01, 'h03, 'h06, 'h0C, 'h18, 'h30, 'h60, 'hC0, 'h80, 'h00};

    initial begin
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; left[k] = 0; rid[k] = 0; drn[k] = 0; msk[k] = '0; md[k] = 1'b0;
            for (int t = 0; t < CYC; t++) begin
                sch_en[k][t] = '0; sch_id[k][t] = '0;
            end
        end
        repeat (3) step();
        RST_N = 1'b1;
        step();

        // broadcast, 8 rows, valid held high
        s = cyc; cmd(8, 8'hFF, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (16) step(); quiet(); step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_en%0d", i), int'(log_en[0][s+2+i]), 'hFF);
            chk($sformatf("t1_id%0d", i), int'(log_id[0][s+2+i]), i);
        end
        chk("t1_en_after", int'(log_en[0][s+10]), 0);
        chk("t1_done", int'(log_done[0][s+10]), 1);
        chk("t1_done_early", int'(log_done[0][s+9]), 0);

        // skew, 2 rows
        s = cyc; cmd(2, 8'hFF, 1'b1); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (16) step(); quiet(); step();
        for (int j = 0; j < 10; j++)
            chk($sformatf("t2_skew%0d", j), int'(log_en[0][s+2+j]), sk_tab[j]);
        chk("t2_done", int'(log_done[0][s+11]), 1);
        chk("t2_done_early", int'(log_done[0][s+10]), 0);

        // bubbles: valid 1,0,1,1
        s = cyc; cmd(3, 8'hFF, 1'b0); step(); i_Start = 1'b0;
        i_W_Valid = 1'b1; step(); i_W_Valid = 1'b0; step();
        i_W_Valid = 1'b1; step(); step(); i_W_Valid = 1'b0;
        repeat (16) step();
        chk("t3_en0", int'(log_en[0][s+2]), 'hFF);
        chk("t3_en1", int'(log_en[0][s+3]), 'h00);
        chk("t3_en2", int'(log_en[0][s+4]), 'hFF);
        chk("t3_en3", int'(log_en[0][s+5]), 'hFF);
        chk("t3_id0", int'(log_id[0][s+2]), 0);
        chk("t3_id2", int'(log_id[0][s+4]), 1);
        chk("t3_id3", int'(log_id[0][s+5]), 2);

        // abort after 3 beats, then a fresh command
        s = cyc; cmd(8, 8'hFF, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (3) step();
        i_Abort = 1'b1; step(); i_Abort = 1'b0; i_W_Valid = 1'b0; step();
        cmd(1, 8'h81, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (16) step(); quiet(); step();
        chk("t4_en_pre", int'(log_en[0][s+4]), 'hFF);
        chk("t4_en_post", int'(log_en[0][s+5]), 0);
        chk("t4_busy_post", int'(log_busy[0][s+5]), 0);
        any = 0;
        for (int i = 0; i < 6; i++) any |= int'(log_done[0][s+i]);
        chk("t4_no_done", any, 0);
        chk("t4_restart_en", int'(log_en[0][s+8]), 'h81);
        chk("t4_restart_done", int'(log_done[0][s+9]), 1);

        // zero rows
        s = cyc; cmd(0, 8'hFF, 1'b0); i_W_Valid = 1'b1; step(); quiet();
        repeat (4) step();
        chk("t5_zero_done", int'(log_done[0][s+1]), 1);
        any = 0;
        for (int i = 0; i < 4; i++) any |= int'(log_en[0][s+i]);
        chk("t5_zero_noen", any, 0);

        // start while busy is ignored
        s = cyc; cmd(4, 8'hFF, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        step(); cmd(1, 8'h0F, 1'b1); step(); i_Start = 1'b0;
        repeat (16) step(); quiet(); step();
        chk("t5_busy_en", int'(log_en[0][s+3]), 'hFF);
        chk("t5_busy_id", int'(log_id[0][s+5]), 3);
        chk("t5_busy_done", int'(log_done[0][s+6]), 1);

        // reset mid-load clears outputs asynchronously
        cmd(8, 8'hFF, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (3) step();
        RST_N = 1'b0; #1;
        chk("t5_rst_en", int'(a_en), 0);
        chk("t5_rst_busy", int'(a_busy), 0);
        chk("t5_rst_rdy", int'(a_rdy), 0);
        quiet(); step(); step();
        RST_N = 1'b1; step();

        // depth 4, partial mask
        s = cyc; cmd(1, 8'h0F, 1'b0); i_W_Valid = 1'b1; step(); i_Start = 1'b0;
        repeat (10) step(); quiet(); step();
        chk("t6_en_early", int'(log_en[1][s+4]), 0);
        chk("t6_en", int'(log_en[1][s+5]), 'h0F);
        chk("t6_d1_en", int'(log_en[0][s+2]), 'h0F);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_Start    = ($urandom_range(0, 3) == 0);
            i_Num_Rows = 4'($urandom_range(0, 15));
            i_Col_Mask = 8'($urandom);
            i_Mode     = 1'($urandom_range(0, 1));
            i_W_Valid  = ($urandom_range(0, 2) != 0);
            i_Abort    = ($urandom_range(0, 49) == 0);
            step();
        end
        quiet();
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
